muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 136 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer between the pipeline and an iterative mult/div unit; owns architectural HI/LO.
// Optional RUN watchdog enabled by defining MULDIV_TIMEOUT_EN (period = TIMEOUT_CYCLES).
module muldiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_reset,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_divby0,
  input  logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FIN} state_t;

  state_t state;
  logic   md_clr;

`ifdef MULDIV_TIMEOUT_EN
  logic [31:0] run_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // The unit is also held in reset for as long as the block itself is.
  assign md_reset = md_clr | reset;

  // Control FSM with registered operand latches, HI/LO and status pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      md_clr   <= 1'b0;
      md_op    <= 1'b0;
      md_a     <= 32'd0;
      md_b     <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout  <= 1'b0;
      run_cnt  <= 32'd0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            md_op  <= op;
            md_a   <= a;
            md_b   <= b;
            md_clr <= 1'b1;
            busy   <= 1'b1;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          md_clr <= 1'b0;
          state  <= RUN;
`ifdef MULDIV_TIMEOUT_EN
          run_cnt <= 32'd0;
`endif
        end
        RUN: begin
`ifdef MULDIV_TIMEOUT_EN
          // timeout high means this is the abort cycle: leave without touching HI/LO.
          if (timeout) begin
            timeout <= 1'b0;
            md_clr  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (md_done) begin
            if (md_op && md_divby0) begin
              div_zero <= 1'b1;
            end else begin
              hi <= md_hi;
              lo <= md_lo;
            end
            done  <= 1'b1;
            state <= FIN;
          end else begin
            run_cnt <= run_cnt + 32'd1;
            if (run_cnt == 32'(TIMEOUT_CYCLES - 2)) begin
              timeout <= 1'b1;
              md_clr  <= 1'b1;
            end
          end
`else
          if (md_done) begin
            if (md_op && md_divby0) begin
              div_zero <= 1'b1;
            end else begin
              hi <= md_hi;
              lo <= md_lo;
            end
            done  <= 1'b1;
            state <= FIN;
          end
`endif
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          md_clr <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural mult/div unit, spec vector table,
// hand-written corner sequences and randomized operations against a reference model.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset, start, op, hi_we, lo_we;
  logic [31:0] a, b, wdata;
  logic        md_op, md_reset, md_divby0, md_done;
  logic [31:0] md_a, md_b, md_hi, md_lo;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, timeout;

  int          total = 0;
  int          bad = 0;
  int          unit_lat;
  int          unit_cnt;
  logic [63:0] unit_res;
  logic [31:0] ref_hi, ref_lo;

  muldiv_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_reset(md_reset),
    .md_hi(md_hi), .md_lo(md_lo), .md_divby0(md_divby0), .md_done(md_done),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Signed MIPS semantics: mult -> {hi,lo} product; div -> hi=remainder, lo=quotient.
  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     q, r;
    if (!o) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    q = $signed(x) / $signed(y);
    r = $signed(x) % $signed(y);
    return {r, q};
  endfunction

  // Behavioural iterative unit: result and done appear unit_lat cycles after md_reset drops.
  always @(posedge clock) begin
    if (md_reset) begin
      unit_cnt  <= 0;
      md_done   <= 1'b0;
      md_divby0 <= 1'b0;
      md_hi     <= 32'd0;
      md_lo     <= 32'd0;
    end else if (!md_done) begin
      unit_cnt <= unit_cnt + 1;
      if (unit_cnt + 1 >= unit_lat) begin
        md_done <= 1'b1;
        if (md_op && md_b == 32'd0) begin
          md_divby0 <= 1'b1;
          md_hi     <= 32'hBAD0BAD0;
          md_lo     <= 32'h0BAD0BAD;
        end else begin
          unit_res = ref_result(md_op, md_a, md_b);
          md_hi <= unit_res[63:32];
          md_lo <= unit_res[31:0];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clock); hi_we = 1'b1; wdata = h;
    @(negedge clock); hi_we = 1'b0; lo_we = 1'b1; wdata = l;
    @(negedge clock); lo_we = 1'b0;
    ref_hi = h; ref_lo = l;
    check("preload_hi", hi, ref_hi);
    check("preload_lo", lo, ref_lo);
  endtask

  // One complete operation with latency, capture and pulse checks.
  task automatic do_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y, input int lat);
    logic [63:0] r;
    logic        dz;
    int          k;
    dz = o && (y == 32'd0);
    r  = dz ? 64'd0 : ref_result(o, x, y);
    unit_lat = lat;
    @(negedge clock); start = 1'b1; op = o; a = x; b = y;
    @(negedge clock); start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    k = 1;
    check({tag, "_clear_busy"}, busy, 1);
    check({tag, "_clear_mdreset"}, md_reset, 1);
    check({tag, "_md_a"}, md_a, x);
    check({tag, "_md_b"}, md_b, y);
    check({tag, "_md_op"}, md_op, o);
    while (done !== 1'b1 && k < lat + 20) begin
      @(negedge clock);
      k++;
      if (k == 2) check({tag, "_run_mdreset"}, md_reset, 0);
    end
    check({tag, "_done_cycle"}, k, lat + 3);
    check({tag, "_div_zero"}, div_zero, dz);
    if (!dz) begin
      ref_hi = r[63:32];
      ref_lo = r[31:0];
    end
    check({tag, "_hi"}, hi, ref_hi);
    check({tag, "_lo"}, lo, ref_lo);
    @(negedge clock);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  typedef struct {
    logic        pre;
    logic [31:0] pre_hi, pre_lo;
    logic        o;
    logic [31:0] x, y;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int k;
    logic o;
    logic [31:0] x, y;

    vecs[0] = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd7, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2] = '{1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3] = '{1'b1, 32'h11111111, 32'h22222222, 1'b1, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 1'b1};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0; unit_lat = 1;
    ref_hi = 32'd0; ref_lo = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_timeout", timeout, 0);
    check("rst_md_reset", md_reset, 1);
    check("rst_md_a", md_a, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_md_reset", md_reset, 0);
    check("post_rst_busy", busy, 0);

    // Spec vectors.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].pre) write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      do_op("vec", vecs[i].o, vecs[i].x, vecs[i].y, i + 1);
      check("vec_hi_const", hi, vecs[i].exp_hi);
      check("vec_lo_const", lo, vecs[i].exp_lo);
    end

    // Start and hi_we arriving while busy are both dropped.
    unit_lat = 6;
    @(negedge clock); start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clock); start = 1'b0; hi_we = 1'b0;
    check("busy_md_a_held", md_a, 3);
    check("busy_md_op_held", md_op, 0);
    k = 0;
    while (done !== 1'b1 && k < 40) begin @(negedge clock); k++; end
    check("busy_done_seen", done, 1);
    check("busy_hi", hi, 0);
    check("busy_lo", lo, 15);
    check("busy_div_zero", div_zero, 0);
    ref_hi = 32'd0; ref_lo = 32'd15;
    repeat (4) @(negedge clock);
    check("busy_no_queued_op", busy, 0);

    // Start together with a HI write in IDLE: write lands now, capture overwrites later.
    unit_lat = 2;
    @(negedge clock); start = 1'b1; op = 1'b0; a = 32'd100; b = 32'd200; hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clock); start = 1'b0; hi_we = 1'b0;
    check("same_cycle_write_now", hi, 32'h12345678);
    k = 0;
    while (done !== 1'b1 && k < 40) begin @(negedge clock); k++; end
    check("same_cycle_hi_final", hi, 0);
    check("same_cycle_lo_final", lo, 20000);
    ref_hi = 32'd0; ref_lo = 32'd20000;
    @(negedge clock);

    // Reset in the middle of a long multiply.
    unit_lat = 32;
    @(negedge clock); start = 1'b1; op = 1'b0; a = 32'hFFFF; b = 32'hFFFF;
    @(negedge clock); start = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_md_reset", md_reset, 1);
    @(negedge clock); reset = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    @(negedge clock);
    check("midrst_after_busy", busy, 0);
    check("midrst_after_md_reset", md_reset, 0);
    do_op("after_rst", 1'b0, 32'd6, 32'd7, 3);

    // Unit that never finishes.
    unit_lat = 1000000;
    @(negedge clock); start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
    @(negedge clock); start = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    for (int c = 2; c <= 17; c++) begin
      @(negedge clock);
      if (c < 17) check("to_early", timeout, 0);
    end
    check("to_pulse", timeout, 1);
    check("to_md_reset", md_reset, 1);
    check("to_no_done", done, 0);
    check("to_busy", busy, 1);
    @(negedge clock);
    check("to_idle_busy", busy, 0);
    check("to_pulse_end", timeout, 0);
    check("to_md_reset_end", md_reset, 0);
    check("to_no_done_after", done, 0);
    check("to_hi", hi, ref_hi);
    check("to_lo", lo, ref_lo);
`else
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (timeout !== 1'b0) check("stall_timeout", timeout, 0);
    end
    check("stall_busy", busy, 1);
    check("stall_timeout_final", timeout, 0);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    @(negedge clock);
`endif

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) write_hilo($urandom, $urandom);
      o = 1'($urandom);
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      if (o && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
      do_op("rnd", o, x, y, $urandom_range(1, 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
